// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the Datapath.
// Ports (as seen from the sequencer, modport master):
//   opcode, CON_FF                 in   IR[31:27] and branch-condition flag
//   PCout .. LOout                 out  bus driver selects (at most one high)
//   MAR_enable .. CON_enable       out  register load enables
//   MDR_read[2:0]                  out  MDR mux select (0 = bus, 1 = RAM)
//   Gra, Grb, Grc                  out  IR register-field selects
//   IncPC, RAM_write               out  PC-increment ALU mode, memory write strobe
//   run                            out  high while executing instructions
interface control_sequencer_if;
    logic [4:0] opcode;
    logic       CON_FF;

    logic PCout, ZLowout, ZHighout, MDRout, Rout, BAout, Cout, InPortout, HIout, LOout;
    logic MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable;
    logic R_enable, HI_enable, LO_enable, InPort_enable, OutPort_enable, CON_enable;
    logic [2:0] MDR_read;
    logic Gra, Grb, Grc;
    logic IncPC, RAM_write;
    logic run;

    modport master (
        input  opcode, CON_FF,
        output PCout, ZLowout, ZHighout, MDRout, Rout, BAout, Cout, InPortout, HIout, LOout,
        output MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
        output R_enable, HI_enable, LO_enable, InPort_enable, OutPort_enable, CON_enable,
        output MDR_read, Gra, Grb, Grc, IncPC, RAM_write, run
    );

    modport slave (
        output opcode, CON_FF,
        input  PCout, ZLowout, ZHighout, MDRout, Rout, BAout, Cout, InPortout, HIout, LOout,
        input  MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
        input  R_enable, HI_enable, LO_enable, InPort_enable, OutPort_enable, CON_enable,
        input  MDR_read, Gra, Grb, Grc, IncPC, RAM_write, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Datapath.
// Steps through a three-step fetch (T0..T2) and an opcode-dependent execute
// sequence (T3..T7), then returns to T0. The halt opcode parks the unit in
// HALT until clr.
// Ports:
//   clk    in  system clock, rising edge
//   clr    in  asynchronous active-high reset
//   ctrl   control_sequencer_if.master: opcode/CON_FF in, all control lines out
module control_sequencer #(
    parameter int NUM_STEPS = 8
) (
    input  logic clk,
    input  logic clr,
    control_sequencer_if.master ctrl
);
    localparam int STEP_W = $clog2(NUM_STEPS);

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_HALT = 5'd26;

    typedef enum logic [1:0] {MODE_RESET, MODE_RUN, MODE_HALT} mode_t;

    mode_t             mode;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] last_step;

    logic is_rtype, is_imm, is_mem, is_muldiv, is_negnot, is_branch;

    assign is_rtype  = (ctrl.opcode >= 5'd3) && (ctrl.opcode <= 5'd10);
    assign is_imm    = (ctrl.opcode == OP_LDI) || ((ctrl.opcode >= 5'd11) && (ctrl.opcode <= 5'd13));
    assign is_mem    = (ctrl.opcode == OP_LD) || (ctrl.opcode == OP_ST);
    assign is_muldiv = (ctrl.opcode == 5'd14) || (ctrl.opcode == 5'd15);
    assign is_negnot = (ctrl.opcode == 5'd16) || (ctrl.opcode == 5'd17);
    assign is_branch = (ctrl.opcode == OP_BR);

    // Final T-step of the current opcode; steps after it are skipped.
    // Opcodes without an execute phase (nop, jal, undefined) end at T2.
    always_comb begin
        last_step = STEP_W'(2);
        if (is_rtype || is_imm)
            last_step = STEP_W'(5);
        else if (is_mem)
            last_step = STEP_W'(7);
        else if (is_muldiv || is_branch)
            last_step = STEP_W'(6);
        else if (is_negnot)
            last_step = STEP_W'(4);
        else if ((ctrl.opcode == OP_JR) || (ctrl.opcode == OP_IN) || (ctrl.opcode == OP_OUT) ||
                 (ctrl.opcode == OP_MFHI) || (ctrl.opcode == OP_MFLO))
            last_step = STEP_W'(3);
    end

    // Sequencer state. Halt is decided on leaving T2, once the new
    // instruction's opcode is presented; HALT is only left through clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode <= MODE_RESET;
            step <= '0;
        end else begin
            case (mode)
                MODE_RESET: begin
                    mode <= MODE_RUN;
                    step <= '0;
                end
                MODE_RUN: begin
                    if ((step == STEP_W'(2)) && (ctrl.opcode == OP_HALT)) begin
                        mode <= MODE_HALT;
                        step <= '0;
                    end else if (step == last_step) begin
                        step <= '0;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                MODE_HALT: begin
                    mode <= MODE_HALT;
                end
                default: begin
                    mode <= MODE_RESET;
                    step <= '0;
                end
            endcase
        end
    end

    // Output decode from the registered state (plus opcode, and CON_FF in
    // the branch T6 step). Everything defaults low so RESET and HALT drive
    // nothing, and clr drops any strobe without waiting for a clock edge.
    always_comb begin
        ctrl.PCout = 1'b0;  ctrl.ZLowout = 1'b0;  ctrl.ZHighout = 1'b0;  ctrl.MDRout = 1'b0;
        ctrl.Rout = 1'b0;   ctrl.BAout = 1'b0;    ctrl.Cout = 1'b0;      ctrl.InPortout = 1'b0;
        ctrl.HIout = 1'b0;  ctrl.LOout = 1'b0;
        ctrl.MAR_enable = 1'b0;  ctrl.MDR_enable = 1'b0;  ctrl.IR_enable = 1'b0;
        ctrl.Y_enable = 1'b0;    ctrl.Z_enable = 1'b0;    ctrl.PC_enable = 1'b0;
        ctrl.R_enable = 1'b0;    ctrl.HI_enable = 1'b0;   ctrl.LO_enable = 1'b0;
        ctrl.InPort_enable = 1'b0;  ctrl.OutPort_enable = 1'b0;  ctrl.CON_enable = 1'b0;
        ctrl.MDR_read = 3'd0;
        ctrl.Gra = 1'b0;  ctrl.Grb = 1'b0;  ctrl.Grc = 1'b0;
        ctrl.IncPC = 1'b0;  ctrl.RAM_write = 1'b0;
        ctrl.run = (mode == MODE_RUN);

        if (mode == MODE_RUN) begin
            case (step)
                STEP_W'(0): begin
                    ctrl.PCout = 1'b1; ctrl.MAR_enable = 1'b1; ctrl.IncPC = 1'b1; ctrl.Z_enable = 1'b1;
                end
                STEP_W'(1): begin
                    ctrl.ZLowout = 1'b1; ctrl.PC_enable = 1'b1; ctrl.MDR_enable = 1'b1; ctrl.MDR_read = 3'd1;
                end
                STEP_W'(2): begin
                    ctrl.MDRout = 1'b1; ctrl.IR_enable = 1'b1;
                end
                STEP_W'(3): begin
                    if (is_rtype) begin
                        ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Y_enable = 1'b1;
                    end else if (is_imm) begin
                        ctrl.Grb = 1'b1; ctrl.Y_enable = 1'b1;
                        if (ctrl.opcode == OP_LDI) ctrl.BAout = 1'b1;
                        else ctrl.Rout = 1'b1;
                    end else if (is_mem) begin
                        ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Y_enable = 1'b1;
                    end else if (is_muldiv) begin
                        ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Y_enable = 1'b1;
                    end else if (is_negnot) begin
                        ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Z_enable = 1'b1;
                    end else if (is_branch) begin
                        ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CON_enable = 1'b1;
                    end else if (ctrl.opcode == OP_JR) begin
                        ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PC_enable = 1'b1;
                    end else if (ctrl.opcode == OP_IN) begin
                        ctrl.InPortout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_enable = 1'b1;
                    end else if (ctrl.opcode == OP_OUT) begin
                        ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.OutPort_enable = 1'b1;
                    end else if (ctrl.opcode == OP_MFHI) begin
                        ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_enable = 1'b1;
                    end else if (ctrl.opcode == OP_MFLO) begin
                        ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_enable = 1'b1;
                    end
                end
                STEP_W'(4): begin
                    if (is_rtype) begin
                        ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.Z_enable = 1'b1;
                    end else if (is_imm || is_mem) begin
                        ctrl.Cout = 1'b1; ctrl.Z_enable = 1'b1;
                    end else if (is_muldiv) begin
                        ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Z_enable = 1'b1;
                    end else if (is_negnot) begin
                        ctrl.ZLowout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_enable = 1'b1;
                    end else if (is_branch) begin
                        ctrl.PCout = 1'b1; ctrl.Y_enable = 1'b1;
                    end
                end
                STEP_W'(5): begin
                    if (is_rtype || is_imm) begin
                        ctrl.ZLowout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_enable = 1'b1;
                    end else if (is_mem) begin
                        ctrl.ZLowout = 1'b1; ctrl.MAR_enable = 1'b1;
                    end else if (is_muldiv) begin
                        ctrl.ZLowout = 1'b1; ctrl.LO_enable = 1'b1;
                    end else if (is_branch) begin
                        ctrl.Cout = 1'b1; ctrl.Z_enable = 1'b1;
                    end
                end
                STEP_W'(6): begin
                    if (ctrl.opcode == OP_LD) begin
                        ctrl.MDR_enable = 1'b1; ctrl.MDR_read = 3'd1;
                    end else if (ctrl.opcode == OP_ST) begin
                        ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDR_enable = 1'b1;
                    end else if (is_muldiv) begin
                        ctrl.ZHighout = 1'b1; ctrl.HI_enable = 1'b1;
                    end else if (is_branch && ctrl.CON_FF) begin
                        ctrl.ZLowout = 1'b1; ctrl.PC_enable = 1'b1;
                    end
                end
                default: begin
                    if (ctrl.opcode == OP_LD) begin
                        ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_enable = 1'b1;
                    end else if (ctrl.opcode == OP_ST) begin
                        ctrl.RAM_write = 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer.
// Holds an instruction-level reference model (fetch words followed by a
// per-opcode list of execute words) that is compared against the DUT on
// every falling edge, plus directed checks with literal expected words.
module tb_control_sequencer;
    logic clk;
    logic clr;

    control_sequencer_if cif ();

    control_sequencer #(.NUM_STEPS(8)) dut (
        .clk  (clk),
        .clr  (clr),
        .ctrl (cif.master)
    );

    // Packed view of every output: [30:28] MDR_read, [27] run, [26:0] single-bit lines.
    localparam logic [30:0] M_PCOUT  = 31'h1 << 0;
    localparam logic [30:0] M_ZLO    = 31'h1 << 1;
    localparam logic [30:0] M_ZHI    = 31'h1 << 2;
    localparam logic [30:0] M_MDROUT = 31'h1 << 3;
    localparam logic [30:0] M_ROUT   = 31'h1 << 4;
    localparam logic [30:0] M_BAOUT  = 31'h1 << 5;
    localparam logic [30:0] M_COUT   = 31'h1 << 6;
    localparam logic [30:0] M_INPOUT = 31'h1 << 7;
    localparam logic [30:0] M_HIOUT  = 31'h1 << 8;
    localparam logic [30:0] M_LOOUT  = 31'h1 << 9;
    localparam logic [30:0] M_MAREN  = 31'h1 << 10;
    localparam logic [30:0] M_MDREN  = 31'h1 << 11;
    localparam logic [30:0] M_IREN   = 31'h1 << 12;
    localparam logic [30:0] M_YEN    = 31'h1 << 13;
    localparam logic [30:0] M_ZEN    = 31'h1 << 14;
    localparam logic [30:0] M_PCEN   = 31'h1 << 15;
    localparam logic [30:0] M_REN    = 31'h1 << 16;
    localparam logic [30:0] M_HIEN   = 31'h1 << 17;
    localparam logic [30:0] M_LOEN   = 31'h1 << 18;
    localparam logic [30:0] M_INPEN  = 31'h1 << 19;
    localparam logic [30:0] M_OUTPEN = 31'h1 << 20;
    localparam logic [30:0] M_CONEN  = 31'h1 << 21;
    localparam logic [30:0] M_GRA    = 31'h1 << 22;
    localparam logic [30:0] M_GRB    = 31'h1 << 23;
    localparam logic [30:0] M_GRC    = 31'h1 << 24;
    localparam logic [30:0] M_INCPC  = 31'h1 << 25;
    localparam logic [30:0] M_RAMW   = 31'h1 << 26;
    localparam logic [30:0] M_RUN    = 31'h1 << 27;
    localparam logic [30:0] M_RD1    = 31'h1 << 28;

    localparam logic [30:0] W_T0 = M_PCOUT | M_MAREN | M_INCPC | M_ZEN | M_RUN;

    logic [30:0] dut_word;
    assign dut_word = {cif.MDR_read, cif.run, cif.RAM_write, cif.IncPC, cif.Grc, cif.Grb, cif.Gra,
                       cif.CON_enable, cif.OutPort_enable, cif.InPort_enable, cif.LO_enable,
                       cif.HI_enable, cif.R_enable, cif.PC_enable, cif.Z_enable, cif.Y_enable,
                       cif.IR_enable, cif.MDR_enable, cif.MAR_enable, cif.LOout, cif.HIout,
                       cif.InPortout, cif.Cout, cif.BAout, cif.Rout, cif.MDRout, cif.ZHighout,
                       cif.ZLowout, cif.PCout};

    int tests_run    = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of execute steps each opcode adds after fetch.
    function automatic int execLen(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd10) return 3;
        if (op inside {5'd1, 5'd11, 5'd12, 5'd13}) return 3;
        if (op inside {5'd0, 5'd2}) return 5;
        if (op inside {5'd14, 5'd15, 5'd18}) return 4;
        if (op inside {5'd16, 5'd17}) return 2;
        if (op inside {5'd19, 5'd21, 5'd22, 5'd23, 5'd24}) return 1;
        return 0;
    endfunction

    // Control word for execute step k (k = 0 is T3); branch T6 gets its
    // CON_FF-dependent part added at compare time.
    function automatic logic [30:0] execWord(input logic [4:0] op, input int k);
        logic [30:0] w;
        w = '0;
        if (op >= 5'd3 && op <= 5'd10) begin
            if (k == 0) w = M_GRB | M_ROUT | M_YEN;
            if (k == 1) w = M_GRC | M_ROUT | M_ZEN;
            if (k == 2) w = M_ZLO | M_GRA | M_REN;
        end else if (op inside {5'd1, 5'd11, 5'd12, 5'd13}) begin
            if (k == 0) w = M_GRB | M_YEN | ((op == 5'd1) ? M_BAOUT : M_ROUT);
            if (k == 1) w = M_COUT | M_ZEN;
            if (k == 2) w = M_ZLO | M_GRA | M_REN;
        end else if (op inside {5'd0, 5'd2}) begin
            if (k == 0) w = M_GRB | M_BAOUT | M_YEN;
            if (k == 1) w = M_COUT | M_ZEN;
            if (k == 2) w = M_ZLO | M_MAREN;
            if (k == 3) w = (op == 5'd0) ? (M_MDREN | M_RD1) : (M_GRA | M_ROUT | M_MDREN);
            if (k == 4) w = (op == 5'd0) ? (M_MDROUT | M_GRA | M_REN) : M_RAMW;
        end else if (op inside {5'd14, 5'd15}) begin
            if (k == 0) w = M_GRA | M_ROUT | M_YEN;
            if (k == 1) w = M_GRB | M_ROUT | M_ZEN;
            if (k == 2) w = M_ZLO | M_LOEN;
            if (k == 3) w = M_ZHI | M_HIEN;
        end else if (op inside {5'd16, 5'd17}) begin
            if (k == 0) w = M_GRB | M_ROUT | M_ZEN;
            if (k == 1) w = M_ZLO | M_GRA | M_REN;
        end else if (op == 5'd18) begin
            if (k == 0) w = M_GRA | M_ROUT | M_CONEN;
            if (k == 1) w = M_PCOUT | M_YEN;
            if (k == 2) w = M_COUT | M_ZEN;
        end else if (op == 5'd19) w = M_GRA | M_ROUT | M_PCEN;
        else if (op == 5'd21)    w = M_INPOUT | M_GRA | M_REN;
        else if (op == 5'd22)    w = M_GRA | M_ROUT | M_OUTPEN;
        else if (op == 5'd23)    w = M_HIOUT | M_GRA | M_REN;
        else if (op == 5'd24)    w = M_LOOUT | M_GRA | M_REN;
        return w;
    endfunction

    // Reference model position: in reset, halted, in fetch step m_fetch
    // (0..2), or executing step m_k of opcode m_op (m_fetch == 3).
    bit         m_reset = 1'b1;
    bit         m_halt  = 1'b0;
    int         m_fetch = 0;
    int         m_k     = 0;
    logic [4:0] m_op    = 5'd25;

    initial begin
        forever begin
            @(posedge clk or posedge clr);
            if (clr) begin
                m_reset = 1'b1;
                m_halt  = 1'b0;
            end else if (m_reset) begin
                m_reset = 1'b0;
                m_fetch = 0;
            end else if (m_halt) begin
                m_halt = 1'b1;
            end else if (m_fetch < 2) begin
                m_fetch = m_fetch + 1;
            end else if (m_fetch == 2) begin
                m_op = cif.opcode;
                if (m_op == 5'd26) m_halt = 1'b1;
                else if (execLen(m_op) == 0) m_fetch = 0;
                else begin
                    m_fetch = 3;
                    m_k     = 0;
                end
            end else if (m_k + 1 < execLen(m_op)) begin
                m_k = m_k + 1;
            end else begin
                m_fetch = 0;
            end
        end
    end

    function automatic logic [30:0] modelWord();
        if (m_reset || m_halt) return '0;
        case (m_fetch)
            0: return W_T0;
            1: return M_ZLO | M_PCEN | M_MDREN | M_RD1 | M_RUN;
            2: return M_MDROUT | M_IREN | M_RUN;
            default: begin
                if (m_op == 5'd18 && m_k == 3)
                    return (cif.CON_FF ? (M_ZLO | M_PCEN) : 31'h0) | M_RUN;
                return execWord(m_op, m_k) | M_RUN;
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [30:0] actual, input logic [30:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial begin
        @(negedge clk);
        forever begin
            checkOutput("model", dut_word, modelWord());
            @(negedge clk);
        end
    end

    task automatic applyStimulus(input logic [4:0] op, input logic con);
        #1;
        cif.opcode = op;
        cif.CON_FF = con;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFetchStart();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!(m_fetch == 0 && !m_reset && !m_halt) && n < 12);
        if (n >= 12) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL timeout: no return to T0 within 12 cycles, op %0d", m_op);
        end
    endtask

    task automatic pulseClr();
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
    endtask

    logic [4:0] sweep_ops [24] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                   5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18,
                                   5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};

    initial begin
        clr        = 1'b0;
        cif.opcode = 5'd25;
        cif.CON_FF = 1'b0;
        #1 clr = 1'b1;

        // Reset held for two cycles, then fetch starts at T0.
        stepCycles(2);
        checkOutput("reset idle", dut_word, 31'h0);
        #1 clr = 1'b0;
        @(negedge clk);
        checkOutput("T0 after reset", dut_word, W_T0);

        // add: three execute steps then back to T0.
        applyStimulus(5'd3, 1'b0);
        stepCycles(3);
        checkOutput("add T3", dut_word, M_GRB | M_ROUT | M_YEN | M_RUN);
        stepCycles(1);
        checkOutput("add T4", dut_word, M_GRC | M_ROUT | M_ZEN | M_RUN);
        stepCycles(1);
        checkOutput("add T5", dut_word, M_ZLO | M_GRA | M_REN | M_RUN);
        stepCycles(1);
        checkOutput("add next T0", dut_word, W_T0);

        // Branch taken and not taken.
        applyStimulus(5'd18, 1'b1);
        stepCycles(6);
        checkOutput("br taken T6", dut_word, M_ZLO | M_PCEN | M_RUN);
        stepCycles(1);
        checkOutput("br taken next T0", dut_word, W_T0);
        applyStimulus(5'd18, 1'b0);
        stepCycles(6);
        checkOutput("br not taken T6", dut_word, M_RUN);
        stepCycles(1);
        checkOutput("br not taken next T0", dut_word, W_T0);

        // st: bus-sourced MDR load, then a single write strobe.
        applyStimulus(5'd2, 1'b0);
        stepCycles(6);
        checkOutput("st T6", dut_word, M_GRA | M_ROUT | M_MDREN | M_RUN);
        stepCycles(1);
        checkOutput("st T7", dut_word, M_RAMW | M_RUN);
        stepCycles(1);
        checkOutput("st next T0", dut_word, W_T0);

        // Remaining opcodes, checked by the model each cycle.
        foreach (sweep_ops[i]) begin
            applyStimulus(sweep_ops[i], 1'($urandom_range(0, 1)));
            waitFetchStart();
        end
        applyStimulus(5'd31, 1'b1);
        waitFetchStart();
        checkOutput("T0 after undefined op", dut_word, W_T0);

        // halt: parks after T2 with everything low.
        applyStimulus(5'd26, 1'b0);
        stepCycles(3);
        for (int c = 0; c < 20; c++) begin
            checkOutput("halt idle", dut_word, 31'h0);
            @(negedge clk);
        end
        applyStimulus(5'd25, 1'b0);
        pulseClr();
        checkOutput("T0 after halt clr", dut_word, W_T0);

        // clr mid-T4 of ld clears outputs without a clock edge.
        applyStimulus(5'd0, 1'b0);
        stepCycles(4);
        checkOutput("ld T4", dut_word, M_COUT | M_ZEN | M_RUN);
        #2 clr = 1'b1;
        #1 checkOutput("async clr ld", dut_word, 31'h0);
        @(negedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        checkOutput("T0 after ld abort", dut_word, W_T0);

        // clr during the st write strobe drops RAM_write at once.
        applyStimulus(5'd2, 1'b0);
        stepCycles(7);
        checkOutput("st T7 pre-abort", dut_word, M_RAMW | M_RUN);
        #2 clr = 1'b1;
        #1 checkOutput("async clr st", dut_word, 31'h0);
        @(negedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        checkOutput("T0 after st abort", dut_word, W_T0);

        stepCycles(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
